// File: rtl/processor_pkg.sv
// Shared definitions for the register-file-plus-ALU execute stage:
// op-code encodings and register-file geometry.
package processor_pkg;

   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int OP_W       = 7;

   localparam logic [OP_W-1:0] OP_NOP  = 7'h00;
   localparam logic [OP_W-1:0] OP_READ = 7'h01;
   localparam logic [OP_W-1:0] OP_LDI  = 7'h02;
   localparam logic [OP_W-1:0] OP_LDU  = 7'h03;
   localparam logic [OP_W-1:0] OP_ADD  = 7'h04;
   localparam logic [OP_W-1:0] OP_SUB  = 7'h05;
   localparam logic [OP_W-1:0] OP_AND  = 7'h06;
   localparam logic [OP_W-1:0] OP_OR   = 7'h07;
   localparam logic [OP_W-1:0] OP_XOR  = 7'h08;
   localparam logic [OP_W-1:0] OP_SLL  = 7'h09;
   localparam logic [OP_W-1:0] OP_SRL  = 7'h0A;
   localparam logic [OP_W-1:0] OP_SRA  = 7'h0B;
   localparam logic [OP_W-1:0] OP_MOV  = 7'h0C;
   localparam logic [OP_W-1:0] OP_ADDI = 7'h0D;

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU for the execute stage. Operand a is R[rs1] (also the
// destination), b is R[rs2], imm is the raw immediate. Unknown op codes
// produce no write.
module processor_alu
   import processor_pkg::*;
#(
   parameter int WORDSIZE = 64,
   parameter int SIZE     = 32
) (
   input  logic [WORDSIZE-1:0] a,
   input  logic [WORDSIZE-1:0] b,
   input  logic [SIZE-1:0]     imm,
   input  logic [OP_W-1:0]     op,
   output logic [WORDSIZE-1:0] result,
   output logic                write_en
);

   // Low bits kept by LDU; all-zero when the immediate covers the whole word.
   localparam logic [WORDSIZE-1:0] LOW_MASK = {WORDSIZE{1'b1}} >> SIZE;

   logic [WORDSIZE-1:0] imm_sext;
   logic [WORDSIZE-1:0] imm_upper;
   logic [5:0]          shamt;

   // Immediate forms and shift amount derived from the operands.
   always_comb begin
      imm_sext  = WORDSIZE'($signed(imm));
      imm_upper = WORDSIZE'(imm) << (WORDSIZE - SIZE);
      shamt     = b[5:0];
   end

   // Operation select; write_en marks the ops that update R[rs1].
   always_comb begin
      result   = '0;
      write_en = 1'b0;
      case (op)
         OP_LDI: begin
            result   = imm_sext;
            write_en = 1'b1;
         end
         OP_LDU: begin
            result   = (a & LOW_MASK) | imm_upper;
            write_en = 1'b1;
         end
         OP_ADD: begin
            result   = a + b;
            write_en = 1'b1;
         end
         OP_SUB: begin
            result   = a - b;
            write_en = 1'b1;
         end
         OP_AND: begin
            result   = a & b;
            write_en = 1'b1;
         end
         OP_OR: begin
            result   = a | b;
            write_en = 1'b1;
         end
         OP_XOR: begin
            result   = a ^ b;
            write_en = 1'b1;
         end
         OP_SLL: begin
            result   = a << shamt;
            write_en = 1'b1;
         end
         OP_SRL: begin
            result   = a >> shamt;
            write_en = 1'b1;
         end
         OP_SRA: begin
            result   = $unsigned($signed(a) >>> shamt);
            write_en = 1'b1;
         end
         OP_MOV: begin
            result   = b;
            write_en = 1'b1;
         end
         OP_ADDI: begin
            result   = a + imm_sext;
            write_en = 1'b1;
         end
         default: begin
            result   = '0;
            write_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/processor_unit.sv
// Execute/register stage: 32-entry register file with accumulator-style
// write-back to R[rs1], registered read ports, and a zero-latency debug view
// of R[rs1]. R[0] reads as zero and ignores writes.
module processor_unit
   import processor_pkg::*;
#(
   parameter int WORDSIZE = 64,
   parameter int SIZE     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic [SIZE-1:0]       rd_in,
   input  logic [OP_W-1:0]       op_code,
   output logic [WORDSIZE-1:0]   rs1_out,
   output logic [WORDSIZE-1:0]   rs2_out,
   output logic [WORDSIZE-1:0]   debug_variable
);

   logic [WORDSIZE-1:0] regs [NUM_REGS];
   logic [WORDSIZE-1:0] rd1;
   logic [WORDSIZE-1:0] rd2;
   logic [WORDSIZE-1:0] alu_result;
   logic                alu_write_en;

   // Read ports with index 0 forced to zero.
   always_comb begin
      rd1 = (rs1 == '0) ? '0 : regs[rs1];
      rd2 = (rs2 == '0) ? '0 : regs[rs2];
      debug_variable = rd1;
   end

   processor_alu #(
      .WORDSIZE (WORDSIZE),
      .SIZE     (SIZE)
   ) u_alu (
      .a        (rd1),
      .b        (rd2),
      .imm      (rd_in),
      .op       (op_code),
      .result   (alu_result),
      .write_en (alu_write_en)
   );

   // Register file: reset loads each entry with its own index; writes to R[0]
   // are dropped so the entry stays at its reset value of zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= WORDSIZE'(i);
         end
      end else if (alu_write_en && (rs1 != '0)) begin
         regs[rs1] <= alu_result;
      end
   end

   // Output registers sample the pre-edge register contents every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs1_out <= '0;
         rs2_out <= '0;
      end else begin
         rs1_out <= rd1;
         rs2_out <= rd2;
      end
   end

endmodule

// File: tb/tb_processor_unit.sv
// Directed plus randomized bench for processor_unit with a reference register
// model and a scoreboard of expected registered outputs.
module tb_processor_unit;

   localparam int W = 64;
   localparam int S = 32;

   logic          clk;
   logic          reset;
   logic [4:0]    rs1;
   logic [4:0]    rs2;
   logic [S-1:0]  rd_in;
   logic [6:0]    op_code;
   logic [W-1:0]  rs1_out;
   logic [W-1:0]  rs2_out;
   logic [W-1:0]  debug_variable;

   typedef struct {
      logic [W-1:0] r1;
      logic [W-1:0] r2;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] model [32];
   int           passed;
   int           total;

   processor_unit #(.WORDSIZE(W), .SIZE(S)) dut (
      .clk            (clk),
      .reset          (reset),
      .rs1            (rs1),
      .rs2            (rs2),
      .rd_in          (rd_in),
      .op_code        (op_code),
      .rs1_out        (rs1_out),
      .rs2_out        (rs2_out),
      .debug_variable (debug_variable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model[i] = W'(i);
   endtask

   function automatic logic [W-1:0] mread(input logic [4:0] idx);
      return (idx == 5'd0) ? '0 : model[idx];
   endfunction

   // Drive one op, push expected registered outputs, update the model,
   // clock once, then pop and compare.
   task automatic step(input logic [6:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [S-1:0] imm);
      exp_t         e;
      logic [W-1:0] a, b, sx, res;
      logic         we;
      op_code = op; rs1 = a1; rs2 = a2; rd_in = imm;
      a  = mread(a1);
      b  = mread(a2);
      e.r1 = a;
      e.r2 = b;
      sb.push_back(e);
      sx = {{(W-S){imm[S-1]}}, imm};
      we = 1'b1;
      res = '0;
      case (op)
         7'h02: res = sx;
         7'h03: res = {imm, a[W-S-1:0]};
         7'h04: res = a + b;
         7'h05: res = a - b;
         7'h06: res = a & b;
         7'h07: res = a | b;
         7'h08: res = a ^ b;
         7'h09: res = a << b[5:0];
         7'h0A: res = a >> b[5:0];
         7'h0B: res = $unsigned($signed(a) >>> b[5:0]);
         7'h0C: res = b;
         7'h0D: res = a + sx;
         default: we = 1'b0;
      endcase
      if (we && a1 != 5'd0) model[a1] = res;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("rs1_out", rs1_out, e.r1);
         check("rs2_out", rs2_out, e.r2);
      end
      check("debug", debug_variable, mread(a1));
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset = 1'b1; rs1 = 5'd4; rs2 = 5'd0; rd_in = '0; op_code = 7'h01;
      model_reset();
      #12;
      check("reset_debug_r4", debug_variable, 64'h4);
      check("reset_rs1_out", rs1_out, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held_rs1_out", rs1_out, 64'h0);
      reset = 1'b0;
      #2;
      check("pre_edge_rs1_out", rs1_out, 64'h0);
      step(7'h01, 5'd4, 5'd0, '0);
      check("read_r4", rs1_out, 64'h4);

      // LDI latency
      step(7'h02, 5'd5, 5'd0, 32'hFFFF_FFFE);
      check("ldi_old_rs1_out", rs1_out, 64'h5);
      check("ldi_debug", debug_variable, 64'hFFFF_FFFF_FFFF_FFFE);
      step(7'h01, 5'd5, 5'd0, '0);
      check("ldi_next_rs1_out", rs1_out, 64'hFFFF_FFFF_FFFF_FFFE);

      // ADD / SUB
      step(7'h04, 5'd2, 5'd3, '0);
      check("add_r2", debug_variable, 64'd5);
      step(7'h05, 5'd2, 5'd3, '0);
      check("sub_r2", debug_variable, 64'd2);
      step(7'h05, 5'd0, 5'd3, '0);
      check("sub_r0", debug_variable, 64'd0);

      // Same register on both ports
      step(7'h04, 5'd9, 5'd9, '0);
      check("add_self", debug_variable, 64'd18);
      step(7'h05, 5'd9, 5'd9, '0);
      check("sub_self", debug_variable, 64'd0);

      // Shifts
      step(7'h02, 5'd7, 5'd0, 32'h0);
      step(7'h03, 5'd7, 5'd0, 32'h8000_0000);
      check("ldu_r7", debug_variable, 64'h8000_0000_0000_0000);
      step(7'h0B, 5'd7, 5'd1, '0);
      check("sra_r7", debug_variable, 64'hC000_0000_0000_0000);
      step(7'h02, 5'd7, 5'd0, 32'h0);
      step(7'h03, 5'd7, 5'd0, 32'h8000_0000);
      step(7'h0A, 5'd7, 5'd1, '0);
      check("srl_r7", debug_variable, 64'h4000_0000_0000_0000);

      // R0 write and illegal op
      step(7'h02, 5'd0, 5'd0, 32'h1234);
      check("r0_ldi", debug_variable, 64'h0);
      step(7'h7F, 5'd7, 5'd1, 32'hDEAD);
      check("illegal_rs1_out", rs1_out, 64'h4000_0000_0000_0000);
      check("illegal_rs2_out", rs2_out, 64'h1);
      check("illegal_r7", debug_variable, 64'h4000_0000_0000_0000);

      // Randomized mix of all ops against the model
      for (int k = 0; k < 80; k++) begin
         step(7'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), $urandom());
      end

      // Asynchronous reset between edges
      step(7'h02, 5'd12, 5'd0, 32'h5555);
      #2;
      reset = 1'b1;
      rs1 = 5'd12;
      #1;
      check("async_rs1_out", rs1_out, 64'h0);
      check("async_rs2_out", rs2_out, 64'h0);
      check("async_r12", debug_variable, 64'd12);
      model_reset();
      sb.delete();
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         #1;
         check("async_reg", debug_variable, W'(i));
      end
      op_code = 7'h02; rs1 = 5'd6; rd_in = 32'h99;
      @(posedge clk);
      #1;
      check("reset_blocks_write", debug_variable, 64'd6);
      reset = 1'b0;
      step(7'h01, 5'd6, 5'd31, '0);
      check("post_reset_r31", rs2_out, 64'd31);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
